// File: rtl/multi_clk_divider.sv
// NUM_CH-channel clock divider with run-time divisors. Each channel makes a near-50% clock and a
// period-start tick. New divisors take effect at period boundaries, and sync restarts all enabled channels in phase.
module multi_clk_divider #(
  parameter int          NUM_CH  = 4,
  parameter int          CH_W    = 2,
  parameter int          CNT_W   = 32,
  parameter int unsigned DEF_DIV = 50000
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  // CH_STOP covers a disabled channel, a channel with divisor 0, and the state after reset.
  // Leaving CH_STOP with a non-zero divisor always goes through the restart path.
  typedef enum logic {
    CH_STOP,
    CH_RUN
  } ch_state_e;

  logic [CNT_W-1:0] shadow_all [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half, last, inc;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_hit;
    logic             reload_ok;

    assign wr_hit    = wr_en && (wr_ch == CH_W'(c));
    assign half      = (active_q + CNT_W'(1)) >> 1;
    assign last      = active_q - CNT_W'(1);
    assign inc       = cnt_q + CNT_W'(1);
    assign reload_ok = (shadow_q != '0);

    // The restart and reload paths read shadow_q, the value before this cycle's write.
    // A write on a boundary or sync cycle therefore only reaches the next period.
    always_comb begin
      // NOTE: every output of this block gets a default first, so no branch can infer a latch.
      state_d  = state_q;
      shadow_d = wr_hit ? wr_data : shadow_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      clk_d    = 1'b0;
      tick_d   = 1'b0;

      if (!en[c]) begin
        state_d  = CH_STOP;
        cnt_d    = '0;
        active_d = shadow_q;
      end else if ((sync || state_q == CH_STOP) && reload_ok) begin
        state_d  = CH_RUN;
        cnt_d    = '0;
        active_d = shadow_q;
        clk_d    = 1'b1;
        tick_d   = 1'b1;
      end else if (state_q == CH_STOP) begin
        cnt_d    = '0;
        active_d = shadow_q;
      end else if (cnt_q == last) begin
        cnt_d    = '0;
        active_d = shadow_q;
        if (reload_ok) begin
          clk_d  = 1'b1;
          tick_d = 1'b1;
        end else begin
          state_d = CH_STOP;
        end
      end else begin
        cnt_d = inc;
        clk_d = (inc < half);
      end
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
      // NOTE: all state, including the divisor registers, is reset, so behaviour after reset is fully defined.
      if (!rst) begin
        state_q  <= CH_STOP;
        shadow_q <= CNT_W'(DEF_DIV);
        active_q <= CNT_W'(DEF_DIV);
        cnt_q    <= '0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments make every register update from the same pre-edge values.
        state_q  <= state_d;
        shadow_q <= shadow_d;
        active_q <= active_d;
        cnt_q    <= cnt_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    assign clk_out[c]    = clk_q;
    assign tick[c]       = tick_q;
    assign shadow_all[c] = shadow_q;
  end

  // Any rd_ch of NUM_CH or above matches no channel and reads back 0.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) rd_data = shadow_all[c];
    end
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed bench for multi_clk_divider: NUM_CH=3 with the default 50000 divisor.
// Each window packs per-cycle samples in time order, so the first sample is the MSB.
module tb_multi_clk_divider;

  logic        clk_50MHz = 1'b0;
  logic        rst;
  logic [2:0]  en;
  logic        sync;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [31:0] wr_data;
  logic [1:0]  rd_ch;
  logic [31:0] rd_data;
  logic [2:0]  clk_out;
  logic [2:0]  tick;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] cv [3];
  logic [31:0] tv [3];

  multi_clk_divider #(
    .NUM_CH (3),
    .CH_W   (2),
    .CNT_W  (32),
    .DEF_DIV(50000)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .rd_ch    (rd_ch),
    .rd_data  (rd_data),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later and shift every channel into its window.
  task automatic step();
    @(posedge clk_50MHz);
    #1;
    for (int c = 0; c < 3; c++) begin
      cv[c] = {cv[c][30:0], clk_out[c]};
      tv[c] = {tv[c][30:0], tick[c]};
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_win();
    for (int c = 0; c < 3; c++) begin
      cv[c] = '0;
      tv[c] = '0;
    end
  endtask

  task automatic set_wr(input logic [1:0] ch, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_data = d;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] ch, input logic [31:0] exp);
    rd_ch = ch;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int tk;
    int first_low;

    rst     = 1'b0;
    en      = 3'b000;
    sync    = 1'b0;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_data = '0;
    rd_ch   = '0;
    clear_win();

    // 1. Reset defaults, asynchronous reset mid-run, then one full 50000-cycle period.
    steps(2);
    check("rst_clk", {29'd0, clk_out}, 32'd0);
    check("rst_tick", {29'd0, tick}, 32'd0);
    rd_check("rst_rd0", 2'd0, 32'd50000);

    rst = 1'b1;
    en  = 3'b001;
    step();
    check("first_tick0", {31'd0, tick[0]}, 32'd1);
    set_wr(2'd0, 32'd7);
    step();
    wr_en = 1'b0;
    rd_check("wr_rd0", 2'd0, 32'd7);
    #2;
    rst = 1'b0;
    #1;
    check("async_clk", {29'd0, clk_out}, 32'd0);
    check("async_tick", {29'd0, tick}, 32'd0);
    rd_check("async_rd0", 2'd0, 32'd50000);
    @(posedge clk_50MHz);
    #1;
    rst = 1'b1;

    step();
    check("rel_tick0", {31'd0, tick[0]}, 32'd1);
    check("rel_clk0", {31'd0, clk_out[0]}, 32'd1);
    hi        = 0;
    tk        = 0;
    first_low = -1;
    for (int i = 1; i < 50000; i++) begin
      step();
      hi += int'(clk_out[0]);
      tk += int'(tick[0]);
      if (!clk_out[0] && first_low < 0) first_low = i;
    end
    check("def_high", 32'(hi), 32'd24999);
    check("def_ticks", 32'(tk), 32'd0);
    check("def_first_low", 32'(first_low), 32'd25000);
    step();
    check("def_period_tick", {31'd0, tick[0]}, 32'd1);

    // 2. Odd divisor on ch1, then a mid-period write and a boundary write.
    en = 3'b000;
    set_wr(2'd1, 32'd5);
    step();
    wr_en = 1'b0;
    rd_check("n5_rd1", 2'd1, 32'd5);
    en = 3'b010;
    clear_win();
    steps(13);
    check("n5_clk", cv[1], 32'b1110011100111);
    check("n5_tick", tv[1], 32'b1000010000100);

    clear_win();
    set_wr(2'd1, 32'd4);
    step();
    wr_en = 1'b0;
    step();
    set_wr(2'd1, 32'd6);
    step();
    wr_en = 1'b0;
    steps(10);
    check("wrb_clk", cv[1], 32'b0011001110001);
    check("wrb_tick", tv[1], 32'b0010001000001);

    // 3. Special divisors on ch2: N=1, N=0, then N=3.
    set_wr(2'd2, 32'd1);
    step();
    wr_en = 1'b0;
    en = 3'b110;
    clear_win();
    steps(4);
    check("n1_clk", cv[2], 32'b1111);
    check("n1_tick", tv[2], 32'b1111);

    clear_win();
    set_wr(2'd2, 32'd0);
    step();
    wr_en = 1'b0;
    steps(3);
    check("n0_clk", cv[2], 32'b1000);
    check("n0_tick", tv[2], 32'b1000);

    clear_win();
    set_wr(2'd2, 32'd3);
    step();
    wr_en = 1'b0;
    steps(5);
    check("n3_clk", cv[2], 32'b011011);
    check("n3_tick", tv[2], 32'b010010);

    // 4. Sync alignment of ch0 (N=4) and ch1 (N=6); ch2 is disabled and must stay quiet.
    en = 3'b010;
    set_wr(2'd0, 32'd4);
    step();
    wr_en = 1'b0;
    en = 3'b011;
    steps(3);
    clear_win();
    sync = 1'b1;
    step();
    sync = 1'b0;
    steps(12);
    check("sync_tick0", tv[0], 32'b1000100010001);
    check("sync_clk0", cv[0], 32'b1100110011001);
    check("sync_tick1", tv[1], 32'b1000001000001);
    check("sync_clk1", cv[1], 32'b1110001110001);
    check("sync_clk2_off", cv[2], 32'd0);
    check("sync_tick2_off", tv[2], 32'd0);

    clear_win();
    sync = 1'b1;
    set_wr(2'd0, 32'd8);
    step();
    sync  = 1'b0;
    wr_en = 1'b0;
    steps(12);
    check("syncwr_tick0", tv[0], 32'b1000100000001);
    check("syncwr_clk0", cv[0], 32'b1100111100001);
    check("syncwr_tick1", tv[1], 32'b1000001000001);

    // 5. Enable gating on ch1 mid-period, then a write to an out-of-range channel.
    steps(2);
    clear_win();
    en = 3'b001;
    steps(2);
    en = 3'b011;
    steps(7);
    check("gate_tick1", tv[1], 32'b001000001);
    check("gate_clk1", cv[1], 32'b001110001);

    set_wr(2'd3, 32'd77);
    step();
    wr_en = 1'b0;
    rd_check("bad_rd0", 2'd0, 32'd8);
    rd_check("bad_rd1", 2'd1, 32'd6);
    rd_check("bad_rd2", 2'd2, 32'd3);
    rd_check("bad_rd3", 2'd3, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
